display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
// - Scan controller for the stopwatch 4-digit multiplexed 7-segment display.
// - Time-multiplexes the four digits and produces the digit-select, anode and 4-bit digit-code signals.
// - Overlays the "-E01" error message for a fixed time when the user requests a mode change while counting.
// - Grants the mode change when the stopwatch is stopped.
// PARAMETERS
// - SCAN_DIV    50000  clk cycles per digit slot; must be >= 2.
// - ERR_FRAMES  500    number of 4-digit frames the error overlay is held; must be >= 1.
// - Both limits are checked by an elaboration-time assertion.
// PORTS
// - clk              in   1   single system clock, rising edge.
// - reset_n          in   1   asynchronous, active-low reset.
// - counting         in   1   stopwatch is running.
// - mode_change_req  in   1   one-cycle pulse: user pressed the mode button.
// - digit_bcd        in   16  four BCD time digits; [3:0] is the rightmost digit (sel=0).
// - sel              out  2   current digit slot, registered.
// - an               out  4   active-low anode enables, registered; an = ~(4'b1 << sel).
// - code             out  4   digit code for the 7-seg decoder; combinational from sel, state and digit_bcd.
// - err_active       out  1   error overlay shown, registered.
// - mode_change_ok   out  1   one-cycle grant pulse, registered.
// BEHAVIOUR
// - Reset values: prescaler=0, sel=0, an=4'b1110, state=IDLE, err_active=0, mode_change_ok=0, frame_cnt=0.
// - After reset, code = digit_bcd[3:0].
// - Prescaler: counts 0..SCAN_DIV-1, then wraps to 0. tick=1 on the cycle prescaler==SCAN_DIV-1.
// - On tick: sel <= sel+1, wrapping 3->0. an follows on the same edge.
// - Frame end = tick && sel==3.
// - FSM IDLE:
//   - req && counting: go to ERR; err_active<=1; frame_cnt<=ERR_FRAMES.
//   - req && !counting: mode_change_ok<=1 for exactly one cycle; state stays IDLE.
// - FSM ERR:
//   - On each frame end: frame_cnt decrements.
//   - Frame end with frame_cnt==1: go to IDLE; err_active<=0.
//   - The overlay therefore covers the partial entry frame plus ERR_FRAMES-1 full frames.
//   - req && counting (retrigger): frame_cnt<=ERR_FRAMES; stay in ERR.
//   - req && !counting: mode_change_ok pulse; go to IDLE at once; err_active<=0.
//   - Simultaneous retrigger and final frame end: the retrigger wins and ERR continues.
// - code in IDLE: digit_bcd[4*sel +: 4]. Values above 9 pass through unchanged (decoder blanks them).
// - code in ERR, by sel 0/1/2/3: 4'b1110 '1', 4'b1101 '0', 4'b1100 'E', 4'b1011 '-'.
//   - Displayed left to right this reads "-E01".
// - The scan never stops; sel and an are unaffected by FSM state.
// - reset_n low at any time, including mid-ERR: all registers return to reset values immediately.
// - mode_change_req high for more than one cycle is treated as repeated requests.
// CONFIGURATION
// - Macro ERR_BLINK_EN:
//   - Defined: in ERR, an=4'b1111 (display blank) on frames where frame_cnt[0] != ERR_FRAMES[0].
//     The entry frame is lit and the overlay alternates lit/blank per frame.
//   - Undefined: the overlay is steady; an always equals ~(1<<sel).
// STRUCTURE
// - Package stopwatch_disp_pkg:
//   - localparams CODE_ERR_ONE=4'b1110, CODE_ERR_ZERO=4'b1101, CODE_ERR_E=4'b1100, CODE_ERR_DASH=4'b1011.
//   - typedef enum logic {IDLE, ERR} disp_state_t.
// - Sub-module tick_gen #(DIV): the prescaler, producing the one-cycle tick.
// - FSM, frame counter and code select stay in display_scan_ctrl.
// TESTING (bench uses SCAN_DIV=4, ERR_FRAMES=2)
// - Reset release:
//   - sel=0, an=1110.
//   - 4 clks later: sel=1, an=1101.
//   - 16 clks after release: sel=0 again.
// - IDLE scan, digit_bcd=16'h1234: code over sel 0..3 = 4,3,2,1; err_active stays 0.
// - counting=1, req pulse:
//   - err_active=1 next edge; code over sel 0..3 = E,D,C,B; mode_change_ok stays 0.
//   - err_active drops at the second frame end.
// - counting=0, req pulse: mode_change_ok=1 for exactly one cycle after the edge; no overlay.
// - Retrigger: req with counting=1 during ERR reloads frame_cnt; overlay lasts to the second frame end after the retrigger.
// - reset_n low mid-ERR: err_active=0, an=1110, sel=0 without waiting for a clk edge.
// - ERR_BLINK_EN build: the second overlay frame shows an=1111 throughout.

Source files
------------

// File: rtl/stopwatch_disp_pkg.sv
// Shared definitions for the stopwatch display scan controller.
// Contents:
//   CODE_ERR_*    digit codes for the "-E01" error overlay. The decoder
//                 maps these codes to the glyphs '1', '0', 'E' and '-'.
//   disp_state_t  overlay FSM states.
package stopwatch_disp_pkg;

  localparam logic [3:0] CODE_ERR_ONE  = 4'b1110;
  localparam logic [3:0] CODE_ERR_ZERO = 4'b1101;
  localparam logic [3:0] CODE_ERR_E    = 4'b1100;
  localparam logic [3:0] CODE_ERR_DASH = 4'b1011;

  typedef enum logic {
    IDLE,
    ERR
  } disp_state_t;

endpackage

// File: rtl/display_scan_ctrl_tick_gen.sv
// Prescaler for the display scan.
// The counter runs 0..DIV-1 and then wraps to 0. tick is high for one
// cycle on the cycle where the counter equals DIV-1.
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   tick     out  one-cycle pulse every DIV clocks
module tick_gen #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan controller for the stopwatch 4-digit multiplexed 7-segment display.
// The block scans the four digits in turn. When the user asks for a mode
// change while the stopwatch is counting, the block shows the "-E01" error
// overlay for a fixed number of frames. When the stopwatch is stopped, the
// block grants the mode change instead.
// Optional feature macro: ERR_BLINK_EN. When it is defined, the overlay
// blanks the display on every other frame.
// Ports:
//   clk              in   1   system clock, rising edge
//   reset_n          in   1   asynchronous active-low reset
//   counting         in   1   stopwatch is running
//   mode_change_req  in   1   mode button pulse
//   digit_bcd        in   16  BCD digits; [3:0] is the rightmost digit (sel=0)
//   sel              out  2   current digit slot (registered)
//   an               out  4   active-low anodes (registered)
//   code             out  4   digit code for the decoder (combinational)
//   err_active       out  1   error overlay is shown (registered)
//   mode_change_ok   out  1   one-cycle grant pulse (registered)
module display_scan_ctrl
  import stopwatch_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned ERR_FRAMES = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        counting,
  input  logic        mode_change_req,
  input  logic [15:0] digit_bcd,
  output logic [1:0]  sel,
  output logic [3:0]  an,
  output logic [3:0]  code,
  output logic        err_active,
  output logic        mode_change_ok
);

  if (SCAN_DIV < 2 || ERR_FRAMES < 1) begin : g_param_check
    $error("display_scan_ctrl: SCAN_DIV must be >= 2 and ERR_FRAMES >= 1");
  end

  localparam int unsigned FW = $clog2(ERR_FRAMES + 1);
  localparam logic [FW-1:0] ERR_LOAD = FW'(ERR_FRAMES);

  logic          tick;
  logic          frame_end;
  logic [1:0]    sel_n;
  logic [3:0]    an_n;
  disp_state_t   state, state_n;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic          ok_n;

  tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign frame_end = tick && (sel == 2'd3);

  // The overlay FSM and the frame counter.
  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    ok_n        = 1'b0;
    unique case (state)
      IDLE: begin
        if (mode_change_req && counting) begin
          state_n     = ERR;
          frame_cnt_n = ERR_LOAD;
        end else if (mode_change_req) begin
          ok_n = 1'b1;
        end
      end
      ERR: begin
        // A retrigger takes priority over the final frame end.
        if (mode_change_req && counting) begin
          frame_cnt_n = ERR_LOAD;
        end else if (mode_change_req) begin
          ok_n    = 1'b1;
          state_n = IDLE;
        end else if (frame_end) begin
          frame_cnt_n = frame_cnt - FW'(1);
          if (frame_cnt == FW'(1)) begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The anodes are derived from the next-state values. This keeps them
  // registered and aligned with sel on the same edge.
  always_comb begin
    sel_n = tick ? sel + 2'd1 : sel;
`ifdef ERR_BLINK_EN
    if (state_n == ERR && (frame_cnt_n[0] != ERR_LOAD[0])) begin
      an_n = '1;
    end else begin
      an_n = ~(4'b0001 << sel_n);
    end
`else
    an_n = ~(4'b0001 << sel_n);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel            <= '0;
      an             <= 4'b1110;
      state          <= IDLE;
      frame_cnt      <= '0;
      err_active     <= 1'b0;
      mode_change_ok <= 1'b0;
    end else begin
      sel            <= sel_n;
      an             <= an_n;
      state          <= state_n;
      frame_cnt      <= frame_cnt_n;
      err_active     <= (state_n == ERR);
      mode_change_ok <= ok_n;
    end
  end

  // Select the digit code. Values above 9 pass through; the decoder blanks them.
  always_comb begin
    code = digit_bcd[4*sel +: 4];
    if (state == ERR) begin
      unique case (sel)
        2'd0: code = CODE_ERR_ONE;
        2'd1: code = CODE_ERR_ZERO;
        2'd2: code = CODE_ERR_E;
        2'd3: code = CODE_ERR_DASH;
        default: code = CODE_ERR_ONE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl (SCAN_DIV=4, ERR_FRAMES=2).
// cyc counts clock edges since the last reset release. A tick falls on every
// 4th edge, and a frame end falls on every 16th edge.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        counting;
  logic        mode_change_req;
  logic [15:0] digit_bcd;
  logic [1:0]  sel;
  logic [3:0]  an;
  logic [3:0]  code;
  logic        err_active;
  logic        mode_change_ok;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  display_scan_ctrl #(
    .SCAN_DIV   (4),
    .ERR_FRAMES (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .counting        (counting),
    .mode_change_req (mode_change_req),
    .digit_bcd       (digit_bcd),
    .sel             (sel),
    .an              (an),
    .code            (code),
    .err_active      (err_active),
    .mode_change_ok  (mode_change_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to edge number target. Returns 1 time unit after that edge.
  task automatic goto(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic pulse_req(input logic cnt_v);
    counting        = cnt_v;
    mode_change_req = 1'b1;
    goto(cyc + 1);
    mode_change_req = 1'b0;
  endtask

  logic [3:0] an_blank2;

  initial begin
`ifdef ERR_BLINK_EN
    an_blank2 = 4'b1111;
`else
    an_blank2 = 4'b1110;
`endif
    reset_n = 1'b0; counting = 1'b0; mode_change_req = 1'b0; digit_bcd = 16'h1234;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    cyc = 0;

    // Reset state and the IDLE scan.
    check("rst_sel", 16'(sel), 16'd0);
    check("rst_an", 16'(an), 16'b1110);
    check("rst_err", 16'(err_active), 16'd0);
    check("rst_ok", 16'(mode_change_ok), 16'd0);
    check("rst_code", 16'(code), 16'h4);
    goto(4);
    check("s1_sel", 16'(sel), 16'd1);
    check("s1_an", 16'(an), 16'b1101);
    check("s1_code", 16'(code), 16'h3);
    goto(8);
    check("s2_code", 16'(code), 16'h2);
    check("s2_an", 16'(an), 16'b1011);
    goto(12);
    check("s3_code", 16'(code), 16'h1);
    check("s3_an", 16'(an), 16'b0111);
    goto(16);
    check("wrap_sel", 16'(sel), 16'd0);
    check("idle_err", 16'(err_active), 16'd0);

    // Request while counting: the overlay runs to the second frame end (edge 48).
    pulse_req(1'b1);                         // edge 17
    check("err_on", 16'(err_active), 16'd1);
    check("err_c0", 16'(code), 16'he);
    check("err_an0", 16'(an), 16'b1110);
    check("err_ok", 16'(mode_change_ok), 16'd0);
    goto(20);
    check("err_c1", 16'(code), 16'hd);
    goto(24);
    check("err_c2", 16'(code), 16'hc);
    goto(28);
    check("err_c3", 16'(code), 16'hb);
    goto(33);
    check("err_frame2", 16'(err_active), 16'd1);
    check("blink_an", 16'(an), 16'(an_blank2));
    goto(47);
    check("err_hold", 16'(err_active), 16'd1);
    goto(48);
    check("err_off", 16'(err_active), 16'd0);
    check("err_off_code", 16'(code), 16'h4);
    check("err_off_an", 16'(an), 16'b1110);

    // Request while stopped: a one-cycle grant and no overlay.
    pulse_req(1'b0);                         // edge 49
    check("ok_pulse", 16'(mode_change_ok), 16'd1);
    check("ok_noerr", 16'(err_active), 16'd0);
    goto(50);
    check("ok_single", 16'(mode_change_ok), 16'd0);

    // Retrigger: entry at edge 51, frame end at 64, retrigger at 71.
    // The frame end at 80 leaves the overlay up.
    counting = 1'b1;
    pulse_req(1'b1);                         // edge 51
    goto(70);
    pulse_req(1'b1);                         // edge 71
    goto(80);
    check("retrig_hold", 16'(err_active), 16'd1);
    // A retrigger on the final frame end (edge 96) wins. The overlay ends at 128.
    goto(95);
    pulse_req(1'b1);                         // edge 96
    check("retrig_tie", 16'(err_active), 16'd1);
    goto(127);
    check("tie_hold", 16'(err_active), 16'd1);
    goto(128);
    check("tie_off", 16'(err_active), 16'd0);

    // A grant during ERR leaves the overlay at once.
    pulse_req(1'b1);                         // edge 129
    goto(132);
    pulse_req(1'b0);                         // edge 133
    check("err_ok_pulse", 16'(mode_change_ok), 16'd1);
    check("err_ok_exit", 16'(err_active), 16'd0);

    // Asynchronous reset in the middle of ERR.
    pulse_req(1'b1);                         // edge 134
    goto(141);
    #2 reset_n = 1'b0;
    #1;
    check("arst_err", 16'(err_active), 16'd0);
    check("arst_an", 16'(an), 16'b1110);
    check("arst_sel", 16'(sel), 16'd0);
    check("arst_code", 16'(code), 16'h4);
    #2 reset_n = 1'b1;
    cyc = 0;

    // Digit values above 9 pass through unchanged.
    digit_bcd = 16'hfa0c;
    #1;
    check("hex_c0", 16'(code), 16'hc);
    goto(8);
    check("hex_c2", 16'(code), 16'ha);
    goto(12);
    check("hex_c3", 16'(code), 16'hf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
